op_key_conditioner: RTL



---
 rtl/op_key_pkg.sv | 37 +++
 rtl/key_sync2.sv | 23 ++
 rtl/op_key_conditioner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/op_key_pkg.sv
// Shared types and constants for the operator key conditioner.
package op_key_pkg;

  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    FIRE     = 3'd2,
    WAIT_REL = 3'd3,
    REL_DEB  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] keys);
    logic [NUM_KEYS-1:0] one;
    one = 1;
    return (keys != '0) && ((keys & (keys - one)) == '0);
  endfunction

  function automatic logic [1:0] encode(input logic [NUM_KEYS-1:0] keys);
    logic [1:0] code;
    case (keys)
      4'b0001: code = OP_ADD;
      4'b0010: code = OP_SUB;
      4'b0100: code = OP_MUL;
      4'b1000: code = OP_DIV;
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for asynchronous button inputs, synchronous reset.
module key_sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/op_key_conditioner.sv
// Synchronise, debounce and encode four operator buttons into one pulse per press.
// Optional auto-repeat while a single key is held: define OPKEY_REPEAT_EN.
module op_key_conditioner
  import op_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic       op_valid,
  output logic [1:0] op_code,
  output logic       op_err,
  output logic       key_held
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_db_range
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_rpt_range
    $error("REPEAT_CYCLES out of range 1..255");
  end

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t              state;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] cand;
  logic [7:0]          cnt;

  key_sync2 #(
    .WIDTH(NUM_KEYS)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (key_raw),
    .q    (key_s)
  );

`ifdef OPKEY_REPEAT_EN
  localparam logic [7:0] RPT_LAST = 8'(REPEAT_CYCLES - 1);
  logic [7:0] rpt_cnt;
`endif

  // Outputs are registered on the transition into the state that owns them,
  // so they line up exactly with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      op_valid <= 1'b0;
      op_code  <= OP_ADD;
      op_err   <= 1'b0;
      key_held <= 1'b0;
`ifdef OPKEY_REPEAT_EN
      rpt_cnt  <= '0;
`endif
    end else begin
      op_valid <= 1'b0;
      op_code  <= OP_ADD;
      op_err   <= 1'b0;
`ifdef OPKEY_REPEAT_EN
      rpt_cnt  <= '0;
`endif
      unique case (state)
        IDLE: begin
          key_held <= 1'b0;
          if (key_s != '0) begin
            cand  <= key_s;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s != cand) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state <= FIRE;
            if (is_onehot(cand)) begin
              op_valid <= 1'b1;
              op_code  <= encode(cand);
            end else begin
              op_err <= 1'b1;
            end
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        FIRE: begin
          state    <= WAIT_REL;
          cnt      <= '0;
          key_held <= 1'b1;
        end
        WAIT_REL: begin
          key_held <= 1'b1;
          if (key_s == '0) begin
            cnt   <= '0;
            state <= REL_DEB;
          end
`ifdef OPKEY_REPEAT_EN
          // Only a steady single-key hold repeats; any set change restarts the hold.
          else if (key_s == cand && is_onehot(cand)) begin
            if (rpt_cnt == RPT_LAST) begin
              state    <= FIRE;
              op_valid <= 1'b1;
              op_code  <= encode(cand);
              key_held <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 8'd1;
            end
          end
`endif
        end
        REL_DEB: begin
          if (key_s != '0) begin
            state <= WAIT_REL;
          end else if (cnt == DB_LAST) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule
